// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: requester identity,
// controller states and the timeout counter width.
package mem_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_I = 2'd1,
        S_WAIT_D = 2'd2
    } state_e;

    localparam int TIMEOUT_W = 8;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb2_fair.sv
// Two-way fair pick between fetch and load/store requesters, with a lock
// that freezes the choice while a presented request waits for acceptance.
module arb2_fair
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic mem_gnt,
    input  logic arb_en,
    output logic sel
);

    owner_e last_owner_r;
    owner_e lock_sel_r;
    logic   lock_r;
    owner_e pick_s;
    logic   any_req_s;
    logic   grant_s;
    logic   hold_s;

    assign any_req_s = if_req | d_req;
    assign grant_s   = arb_en & any_req_s & mem_gnt;
    assign hold_s    = arb_en & any_req_s & ~mem_gnt;
    assign sel       = pick_s;

    // Contested requests go to whoever did not win last; a held request keeps its pick.
    always_comb begin
        pick_s = OWN_INSTR;
        if (lock_r) begin
            pick_s = lock_sel_r;
        end else if (if_req && d_req) begin
            pick_s = other_owner(last_owner_r);
        end else if (d_req) begin
            pick_s = OWN_DATA;
        end else begin
            pick_s = OWN_INSTR;
        end
    end

    // Fairness history and lock registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_r <= OWN_INSTR;
            lock_sel_r   <= OWN_INSTR;
            lock_r       <= 1'b0;
        end else if (grant_s) begin
            last_owner_r <= pick_s;
            lock_sel_r   <= OWN_INSTR;
            lock_r       <= 1'b0;
        end else if (hold_s) begin
            lock_sel_r   <= pick_s;
            lock_r       <= 1'b1;
        end else begin
            last_owner_r <= last_owner_r;
            lock_sel_r   <= lock_sel_r;
            lock_r       <= lock_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction outstanding at a time, with a response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    // Counter value seen in the last WAIT cycle before a forced error response.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST_C = TIMEOUT_W'(TIMEOUT - 1);

    state_e               state_r;
    owner_e               owner_r;
    logic [TIMEOUT_W-1:0] cnt_r;
    logic                 sel_bit_s;
    owner_e               sel_s;
    logic                 idle_s;
    logic                 waiting_s;
    logic                 any_req_s;
    logic                 present_s;
    logic                 timeout_s;
    logic                 resp_s;

    assign idle_s    = (state_r == S_IDLE);
    assign waiting_s = (state_r == S_WAIT_I) || (state_r == S_WAIT_D);
    assign any_req_s = if_req | d_req;
    assign present_s = idle_s & any_req_s & ~rst;
    assign timeout_s = waiting_s && (cnt_r == CNT_LAST_C);
    assign resp_s    = waiting_s && (mem_rvalid || timeout_s) && !rst;
    assign sel_s     = owner_e'(sel_bit_s);

    arb2_fair u_arb (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .d_req   (d_req),
        .mem_gnt (mem_gnt),
        .arb_en  (idle_s),
        .sel     (sel_bit_s)
    );

    // Request path: route the selected requester's fields and the accept back to it.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = {BE_W{1'b0}};
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if (present_s) begin
            mem_req = 1'b1;
            if (sel_s == OWN_DATA) begin
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_gnt     = mem_gnt;
            end else begin
                mem_be    = {BE_W{1'b1}};
                mem_addr  = if_addr;
                if_gnt    = mem_gnt;
            end
        end else begin
            mem_req = 1'b0;
        end
    end

    // Response path: a real response always beats a coincident timeout.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = {DATA_W{1'b0}};
        if_err    = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = {DATA_W{1'b0}};
        d_err     = 1'b0;
        if (resp_s) begin
            if (owner_r == OWN_DATA) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rvalid ? mem_rdata : {DATA_W{1'b0}};
                d_err    = ~mem_rvalid;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rvalid ? mem_rdata : {DATA_W{1'b0}};
                if_err    = ~mem_rvalid;
            end
        end else begin
            if_rvalid = 1'b0;
        end
    end

    // Transaction FSM with owner and wait-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            owner_r <= OWN_INSTR;
            cnt_r   <= {TIMEOUT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    cnt_r <= {TIMEOUT_W{1'b0}};
                    if (any_req_s && mem_gnt) begin
                        owner_r <= sel_s;
                        state_r <= (sel_s == OWN_DATA) ? S_WAIT_D : S_WAIT_I;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT_I, S_WAIT_D: begin
                    if (resp_s) begin
                        state_r <= S_IDLE;
                        cnt_r   <= {TIMEOUT_W{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r + TIMEOUT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    owner_r <= OWN_INSTR;
                    cnt_r   <= {TIMEOUT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench: a transaction-level model predicts every grant
// and response; a negedge monitor pops and compares what the arbiter presents.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int unsigned cyc;
        int          who;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int unsigned cyc;
        int          who;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t g;
    rsp_t r;

    int n_chk  = 0;
    int n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare presented grants and responses against the scoreboard.
    always @(negedge clk) begin
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            chk("mem_req", 64'(mem_req), 64'd1);
            chk("if_gnt", 64'(if_gnt), 64'(g.who == 0));
            chk("d_gnt", 64'(d_gnt), 64'(g.who == 1));
            chk("mem_addr", 64'(mem_addr), 64'(g.addr));
            chk("mem_we", 64'(mem_we), 64'(g.we));
            if (g.who == 1) begin
                chk("mem_be", 64'(mem_be), 64'(g.be));
                if (g.we) chk("mem_wdata", 64'(mem_wdata), 64'(g.wdata));
            end
        end else begin
            chk("no_gnt", 64'({if_gnt, d_gnt}), 64'd0);
        end
        if (!mem_req)
            chk("idle_fields", 64'(mem_we | (|mem_be) | (|mem_addr) | (|mem_wdata)), 64'd0);
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            chk("if_rvalid", 64'(if_rvalid), 64'(r.who == 0));
            chk("d_rvalid", 64'(d_rvalid), 64'(r.who == 1));
            chk("rdata", 64'((r.who == 1) ? d_rdata : if_rdata), 64'(r.data));
            chk("err", 64'((r.who == 1) ? d_err : if_err), 64'(r.err));
        end else begin
            chk("no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        end
        if (!if_rvalid) chk("if_quiet", 64'(if_err | (|if_rdata)), 64'd0);
        if (!d_rvalid)  chk("d_quiet", 64'(d_err | (|d_rdata)), 64'd0);
    end

    // Reference model state (transaction level)
    bit          i_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] i_a, d_a, d_wd;
    logic        d_w;
    logic [3:0]  d_b;
    bit          busy = 1'b0, round = 1'b0, rsp_real;
    int          last = 0, win = 0, rsp_who = 0;
    int unsigned rsp_due, gnt_at;
    logic [31:0] rsp_dat;

    task automatic new_d();
        d_pend = 1'b1;
        d_a    = $urandom;
        d_w    = 1'($urandom_range(0, 1));
        d_b    = 4'($urandom_range(0, 15));
        d_wd   = $urandom;
    endtask

    task automatic drive_cycle(input bit allow_new, input bit stray_force);
        bit done_now;
        int k;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (allow_new && !i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1;
            i_a    = $urandom;
        end
        if (allow_new && !d_pend && $urandom_range(0, 2) == 0) new_d();
        if_req  = i_pend;
        if_addr = i_a;
        d_req   = d_pend;
        d_addr  = d_a;
        d_we    = d_w;
        d_be    = d_b;
        d_wdata = d_wd;
        done_now   = busy && (cyc == rsp_due);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (busy) begin
            if (done_now && rsp_real) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_dat;
            end
        end else if (stray_force || $urandom_range(0, 5) == 0) begin
            mem_rvalid = 1'b1;
        end
        mem_gnt = 1'b0;
        if (!busy && (i_pend || d_pend)) begin
            // The winner is fixed when the round opens and kept until accepted.
            if (!round) begin
                round = 1'b1;
                if (i_pend && d_pend) win = 1 - last;
                else                  win = d_pend ? 1 : 0;
            end
            if ($urandom_range(0, 2) != 0) begin
                mem_gnt = 1'b1;
                if (win == 1) gq.push_back('{cyc, 1, d_a, d_w, d_b, d_wd});
                else          gq.push_back('{cyc, 0, i_a, 1'b0, 4'hF, 32'd0});
                k       = $urandom_range(0, 9);
                rsp_dat = $urandom;
                gnt_at  = cyc;
                rsp_who = win;
                if (k == 0) begin
                    rsp_real = 1'b0;
                    rsp_due  = cyc + TIMEOUT;
                end else if (k == 1) begin
                    rsp_real = 1'b1;
                    rsp_due  = cyc + TIMEOUT;
                end else begin
                    rsp_real = 1'b1;
                    rsp_due  = cyc + $urandom_range(1, 4);
                end
                rq.push_back('{rsp_due, win, rsp_real ? rsp_dat : 32'd0, !rsp_real});
                busy  = 1'b1;
                last  = win;
                round = 1'b0;
                if (win == 1) d_pend = 1'b0;
                else          i_pend = 1'b0;
            end
        end
        if (done_now) busy = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_gnt"}, 64'({if_gnt, d_gnt}), 64'd0);
        chk({tag, "_rvalid"}, 64'({if_rvalid, d_rvalid}), 64'd0);
        chk({tag, "_err"}, 64'({if_err, d_err}), 64'd0);
        chk({tag, "_rdata"}, 64'(if_rdata | d_rdata), 64'd0);
        chk({tag, "_fields"}, 64'(mem_we | (|mem_be) | (|mem_addr) | (|mem_wdata)), 64'd0);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h1234;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        i_a = 32'h0; d_a = 32'h0; d_wd = 32'h0; d_w = 1'b0; d_b = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");

        for (int c = 0; c < 1500; c++) drive_cycle(1'b1, 1'b0);

        // Park a fetch in its wait state, then reset two cycles after the grant.
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            drive_cycle(1'b1, 1'b0);
            if (busy && rsp_who == 0 && cyc == gnt_at + 1 && rsp_due > gnt_at + 2) found = 1'b1;
        end
        chk("found_wait_i", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        #1;
        check_outputs_zero("midrst");
        gq.delete();
        rq.delete();
        busy  = 1'b0;
        round = 1'b0;
        last  = 0;
        i_pend = 1'b1;
        i_a    = $urandom;
        new_d();
        drive_cycle(1'b1, 1'b1);
        for (int c = 0; c < 500; c++) drive_cycle(1'b1, 1'b0);

        for (int c = 0; c < 120 && (gq.size() + rq.size() > 0 || i_pend || d_pend || busy); c++)
            drive_cycle(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("drained", 64'(gq.size() + rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
